// File: rtl/frog_hit_detect_pkg.sv
// Shared constants for the frog game: state encodings and visible raster size.
// Also used by the game top-level and the car controllers.
package frog_hit_detect_pkg;
  localparam int c_H_ACTIVE = 640;
  localparam int c_V_ACTIVE = 480;
  localparam int c_CNT_W    = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_GRACE = 3'd2;
  localparam logic [2:0] ST_OVER  = 3'd3;
  localparam logic [2:0] ST_WIN   = 3'd4;
endpackage

// File: rtl/frog_hit_detect_frame_end_tick.sv
// Combinational active-area qualifier and last-visible-pixel strobe.
// Reusable wherever a once-per-frame event is needed.
module frame_end_tick
  import frog_hit_detect_pkg::*;
#(
  parameter int c_ACTIVE_COLS = c_H_ACTIVE,
  parameter int c_ACTIVE_ROWS = c_V_ACTIVE
) (
  input  logic [c_CNT_W-1:0] i_Col_Count,
  input  logic [c_CNT_W-1:0] i_Row_Count,
  output logic               o_Active,
  output logic               o_Frame_End
);
  assign o_Active    = (i_Col_Count < c_CNT_W'(c_ACTIVE_COLS)) &&
                       (i_Row_Count < c_CNT_W'(c_ACTIVE_ROWS));
  assign o_Frame_End = (i_Col_Count == c_CNT_W'(c_ACTIVE_COLS - 1)) &&
                       (i_Row_Count == c_CNT_W'(c_ACTIVE_ROWS - 1));
endmodule

// File: rtl/frog_hit_detect.sv
// Frame-rate frog/car collision detector with lives, grace window and win/lose.
// Overlap is accumulated over the visible frame and resolved on its last pixel.
module frog_hit_detect
  import frog_hit_detect_pkg::*;
#(
  parameter int c_ACTIVE_COLS  = c_H_ACTIVE,
  parameter int c_ACTIVE_ROWS  = c_V_ACTIVE,
  parameter int c_LIVES        = 3,
  parameter int c_GRACE_FRAMES = 60,
  parameter int c_WIN_ROW      = 0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Game_Active,
  input  logic [c_CNT_W-1:0]   i_Col_Count,
  input  logic [c_CNT_W-1:0]   i_Row_Count,
  input  logic                 i_Draw_Frog,
  input  logic                 i_Draw_Car,
  input  logic [c_CNT_W-1:0]   i_Frog_Y,
  output logic                 o_Hit,
  output logic                 o_Frog_Respawn,
  output logic [2:0]           o_Lives,
  output logic                 o_Grace,
  output logic                 o_Game_Over,
  output logic                 o_Win
);
  logic       w_active, w_frame_end, w_ovl_px, w_ovl;
  logic [2:0] r_state;
  logic [2:0] r_lives;
  logic [7:0] r_grace_cnt;
  logic       r_ovl, r_hit, r_respawn, r_grace, r_over, r_win;

  frame_end_tick #(
    .c_ACTIVE_COLS(c_ACTIVE_COLS),
    .c_ACTIVE_ROWS(c_ACTIVE_ROWS)
  ) u_frame_end_tick (
    .i_Col_Count(i_Col_Count),
    .i_Row_Count(i_Row_Count),
    .o_Active   (w_active),
    .o_Frame_End(w_frame_end)
  );

  // The frame-end pixel itself may carry the overlap, so fold it in combinationally.
  assign w_ovl_px = w_active && i_Draw_Frog && i_Draw_Car;
  assign w_ovl    = r_ovl || w_ovl_px;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= ST_IDLE;
      r_lives     <= 3'(c_LIVES);
      r_grace_cnt <= '0;
      r_ovl       <= 1'b0;
      r_hit       <= 1'b0;
      r_respawn   <= 1'b0;
      r_grace     <= 1'b0;
      r_over      <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      r_hit     <= 1'b0;
      r_respawn <= 1'b0;
      if (r_state != ST_IDLE && !i_Game_Active) begin
        // Leaving the game wins over any coincident frame-end.
        r_state     <= ST_IDLE;
        r_lives     <= 3'(c_LIVES);
        r_grace_cnt <= '0;
        r_ovl       <= 1'b0;
        r_grace     <= 1'b0;
        r_over      <= 1'b0;
        r_win       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_lives <= 3'(c_LIVES);
            r_ovl   <= 1'b0;
            if (i_Game_Active) r_state <= ST_PLAY;
          end
          default: begin
            if (w_frame_end)   r_ovl <= 1'b0;
            else if (w_ovl_px) r_ovl <= 1'b1;
            if (w_frame_end) begin
              case (r_state)
                ST_PLAY: begin
                  if (w_ovl) begin
                    r_hit     <= 1'b1;
                    r_respawn <= 1'b1;
                    if (r_lives <= 3'd1) begin
                      r_lives <= 3'd0;
                      r_state <= ST_OVER;
                      r_over  <= 1'b1;
                    end else begin
                      r_lives     <= r_lives - 3'd1;
                      r_state     <= ST_GRACE;
                      r_grace_cnt <= 8'(c_GRACE_FRAMES);
                      r_grace     <= 1'b1;
                    end
                  end else if (i_Frog_Y == c_CNT_W'(c_WIN_ROW)) begin
                    r_state <= ST_WIN;
                    r_win   <= 1'b1;
                  end
                end
                ST_GRACE: begin
                  r_grace_cnt <= r_grace_cnt - 8'd1;
                  if (r_grace_cnt == 8'd1) begin
                    r_state <= ST_PLAY;
                    r_grace <= 1'b0;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign o_Hit          = r_hit;
  assign o_Frog_Respawn = r_respawn;
  assign o_Lives        = r_lives;
  assign o_Grace        = r_grace;
  assign o_Game_Over    = r_over;
  assign o_Win          = r_win;
endmodule

// File: doc/frog_hit_detect.md
Name: frog_hit_detect

Overview:
- Sits downstream of the game top-level draw stage.
- Consumes the per-pixel frog and car draw flags, the Col/Row counters and the frog Y position.
- Detects frog/car pixel overlap once per frame and maintains the lives counter, a post-hit grace window and the win/lose result.
- Its outputs feed the top-level state machine (LOSE/WIN transitions) and the frog controller (respawn request).

Parameters:
- c_ACTIVE_COLS, 640, active pixels per line.
- c_ACTIVE_ROWS, 480, active lines per frame.
- c_LIVES, 3, lives loaded at game start; legal range 1..7.
- c_GRACE_FRAMES, 60, frames of collision immunity after a non-fatal hit; legal range 1..255.
- c_WIN_ROW, 0, frog Y value that counts as reaching the top.

Ports:
- i_Clk  in  1  pixel clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Game_Active  in  1  level; high while the game is RUNNING.
- i_Col_Count  in  10  current pixel column.
- i_Row_Count  in  10  current pixel row.
- i_Draw_Frog  in  1  frog occupies the current pixel.
- i_Draw_Car  in  1  any car occupies the current pixel (OR of all cars).
- i_Frog_Y  in  10  frog top-left row.
- o_Hit  out  1  one-cycle pulse per counted collision.
- o_Frog_Respawn  out  1  one-cycle pulse; frog controller returns the frog to its start position.
- o_Lives  out  3  remaining lives.
- o_Grace  out  1  high during the grace window (used for frog blink).
- o_Game_Over  out  1  level; lives exhausted.
- o_Win  out  1  level; frog reached c_WIN_ROW.

Behaviour:
- Reset (i_Rst_L=0, asynchronous): state IDLE, o_Lives=c_LIVES, overlap flag=0, grace counter=0, all other outputs 0.
- Active pixel: i_Col_Count<c_ACTIVE_COLS and i_Row_Count<c_ACTIVE_ROWS.
- Frame-end tick: the single cycle where Col=c_ACTIVE_COLS-1 and Row=c_ACTIVE_ROWS-1.
- Overlap flag: set on any active pixel with i_Draw_Frog && i_Draw_Car. It is evaluated and cleared on the frame-end tick. An overlap on the frame-end pixel itself counts for the current frame (set and evaluate in the same cycle). Non-active pixels never set the flag.
- All outputs are registered. o_Hit and o_Frog_Respawn assert on the cycle after the frame-end tick and last exactly 1 cycle.
- States:
  - IDLE: o_Lives held at c_LIVES. Moves to PLAY on the first cycle i_Game_Active=1; the overlap flag is cleared on entry.
  - PLAY, at frame-end:
    - If overlap: pulse o_Hit and o_Frog_Respawn, decrement o_Lives. If o_Lives was 1, go to OVER (o_Lives=0). Otherwise go to GRACE and load the grace counter with c_GRACE_FRAMES.
    - Else if i_Frog_Y==c_WIN_ROW: go to WIN.
    - Hit has priority over win in the same frame.
  - GRACE: o_Grace=1 and overlaps are ignored (flag cleared, no hit). The counter decrements on each frame-end tick; on the tick where it reaches 0, go to PLAY. Win is not checked in GRACE.
  - OVER: o_Game_Over=1, held.
  - WIN: o_Win=1, held.
- i_Game_Active=0 in any non-IDLE state: go to IDLE next cycle and reload lives. This has priority over a coincident frame-end tick; no hit is generated.
- The win check samples i_Frog_Y only at frame-end.
- The lives counter never underflows.

Decomposition:
- Shared package: state encodings (IDLE, PLAY, GRACE, OVER, WIN as 3-bit constants) and the 640/480 active-area constants, also used by the game top-level.
- One sub-module, frame_end_tick: produces the registered-free frame-end strobe from Col/Row and the active-area parameters. It is reusable by the car controllers.

Test Plan:
- Reset, then i_Game_Active=1; frog and car overlap for 4 pixels in frame 1 -> exactly one o_Hit pulse, 1 cycle after frame-end; o_Lives=2; o_Grace=1.
- After the hit, overlap in each of the next 60 frames -> no o_Hit, o_Lives stays 2. Overlap in frame 62 -> o_Hit, o_Lives=1.
- c_LIVES=3 with three counted hits -> o_Lives=0, o_Game_Over=1 held. i_Game_Active=0 -> IDLE, o_Lives=3.
- i_Frog_Y=0 with no overlap at frame-end -> o_Win=1. Same frame with overlap -> o_Hit, o_Lives decrements, o_Win=0.
- Overlap only at Col=639/Row=479 -> hit counted. Overlap only at Col=700 (blanking) -> no hit.
- Assert i_Rst_L=0 mid-GRACE (o_Lives=1) -> outputs clear immediately without a clock; o_Lives=3, state IDLE.
